// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a word-addressed register memory with programmable
// wait states, byte strobes and an error response for misaligned or out-of-range addresses.
module apb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic IDLE   = 1'b0;
  localparam logic ACCESS = 1'b1;

  logic                  state;
  logic [3:0]            cnt;
  logic                  pwrite_q;
  logic                  err_q;
  logic [MEM_AW-1:0]     idx_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic [MEM_AW-1:0]     widx;
  logic                  err;
  logic                  commit;

  function automatic logic [DATA_WIDTH-1:0] merge_strb(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_word;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

  assign idx  = paddr[ADDR_WIDTH-1:2];
  assign widx = idx[MEM_AW-1:0];
  assign err  = (paddr[1:0] != 2'b00) || (32'(idx) >= 32'(DEPTH));

  // Outputs decode only registered state, so they cannot glitch.
  assign pready  = (state == ACCESS) && (cnt == 4'd0);
  assign pslverr = pready && err_q;
  assign prdata  = (pready && !pwrite_q && !err_q) ? rd_q : '0;

  // pwdata/pstrb are taken at the completion edge, not at setup.
  assign commit = pready && psel && penable && pwrite_q && !err_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      pwrite_q <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      rd_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state    <= ACCESS;
            pwrite_q <= pwrite;
            idx_q    <= widx;
            err_q    <= err;
            rd_q     <= err ? '0 : mem[widx];
            cnt      <= 4'(WAIT_STATES);
          end
        end
        ACCESS: begin
          // A dropped psel aborts silently; a stray setup phase is ignored.
          if (!psel || cnt == 4'd0) state <= IDLE;
          else                      cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[idx_q] <= merge_strb(mem[idx_q], pwdata, pstrb);
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (WAIT_STATES 1, 0, 3) driven with directed
// and random APB transfers, compared against an array-based memory model.
module tb_apb_slave_mem;

  localparam int NU = 3;
  localparam int WS [NU] = '{1, 0, 3};

  logic        clk;
  logic        presetn;
  logic        psel    [NU];
  logic        penable [NU];
  logic        pwrite  [NU];
  logic [7:0]  paddr   [NU];
  logic [31:0] pwdata  [NU];
  logic [3:0]  pstrb   [NU];
  logic [31:0] prdata  [NU];
  logic        pready  [NU];
  logic        pslverr [NU];

  logic [31:0] model [NU][32];
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    apb_slave_mem #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(32), .WAIT_STATES(WS[g])
    ) u_dut (
      .pclk(clk), .presetn(presetn),
      .psel(psel[g]), .penable(penable[g]), .pwrite(pwrite[g]),
      .paddr(paddr[g]), .pwdata(pwdata[g]), .pstrb(pstrb[g]),
      .prdata(prdata[g]), .pready(pready[g]), .pslverr(pslverr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int u = 0; u < NU; u++)
      for (int i = 0; i < 32; i++) model[u][i] = 32'h0;
  endtask

  task automatic bus_idle(input int u);
    psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0;
    paddr[u] = 8'h0; pwdata[u] = 32'h0; pstrb[u] = 4'h0;
  endtask

  // One full transfer; returns the observed read data. Garbage on pwdata/pstrb in
  // the setup phase exposes any early sampling.
  task automatic xfer(input int u, input bit wr, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input bit b2b, output logic [31:0] rdata);
    int n;
    bit err;
    int idx;
    logic [31:0] w;
    @(negedge clk);
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr; paddr[u] = addr;
    pwdata[u] = ~wdata; pstrb[u] = ~strb;
    @(negedge clk);
    penable[u] = 1'b1; pwdata[u] = wdata; pstrb[u] = strb;
    n = 0;
    while (!pready[u] && n < 40) begin
      check($sformatf("u%0d wait_pslverr", u), {31'b0, pslverr[u]}, 32'h0);
      @(negedge clk);
      n++;
    end
    idx = int'(addr) / 4;
    err = (addr % 4 != 0) || (idx >= 32);
    check($sformatf("u%0d pready", u), {31'b0, pready[u]}, 32'h1);
    check($sformatf("u%0d waits", u), 32'(n), 32'(WS[u]));
    check($sformatf("u%0d pslverr@%h", u, addr), {31'b0, pslverr[u]}, {31'b0, err});
    rdata = prdata[u];
    if (wr || err) check($sformatf("u%0d prdata@%h", u, addr), prdata[u], 32'h0);
    else           check($sformatf("u%0d prdata@%h", u, addr), prdata[u], model[u][idx]);
    if (wr && !err) begin
      w = model[u][idx];
      for (int b = 0; b < 4; b++)
        if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      model[u][idx] = w;
    end
    if (!b2b) begin
      @(negedge clk);
      bus_idle(u);
    end
  endtask

  task automatic rd(input int u, input logic [7:0] addr, output logic [31:0] d);
    xfer(u, 1'b0, addr, 32'h0, 4'h0, 1'b0, d);
  endtask

  task automatic wr(input int u, input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    xfer(u, 1'b1, addr, d, s, 1'b0, dummy);
  endtask

  initial begin
    logic [31:0] d;
    int seen;
    for (int u = 0; u < NU; u++) bus_idle(u);
    clear_model();

    // Reset held three cycles
    presetn = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check("rst_pready", {31'b0, pready[u]}, 32'h0);
      check("rst_pslverr", {31'b0, pslverr[u]}, 32'h0);
      check("rst_prdata", prdata[u], 32'h0);
    end
    presetn = 1'b1;
    rd(0, 8'h00, d);
    check("rst_read0", d, 32'h0);

    // Full word write/read, byte strobes, zero strobe (WAIT_STATES=1)
    wr(0, 8'h04, 32'hDEAD_BEEF, 4'hF);
    rd(0, 8'h04, d);
    check("full_word", d, 32'hDEAD_BEEF);
    wr(0, 8'h04, 32'h1122_3344, 4'b0101);
    rd(0, 8'h04, d);
    check("strobe_merge", d, 32'hDE22_BE44);
    wr(0, 8'h04, 32'hFFFF_FFFF, 4'b0000);
    rd(0, 8'h04, d);
    check("strobe_zero", d, 32'hDE22_BE44);

    // Errors
    wr(0, 8'h02, 32'h5555_5555, 4'hF);
    rd(0, 8'h00, d);
    check("misaligned_nomod", d, 32'h0);
    rd(0, 8'h80, d);
    check("oor_read", d, 32'h0);
    wr(0, 8'hFC, 32'h1234_5678, 4'hF);

    // Back-to-back, zero wait states
    xfer(1, 1'b1, 8'h08, 32'hA5A5_A5A5, 4'hF, 1'b1, d);
    xfer(1, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0, d);
    check("b2b_read", d, 32'hA5A5_A5A5);

    // Abort by dropping psel during a WAIT_STATES=3 write
    wr(2, 8'h10, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h10;
    pwdata[2] = 32'h0BAD_0BAD; pstrb[2] = 4'hF;
    @(negedge clk);
    penable[2] = 1'b1;
    @(negedge clk);
    bus_idle(2);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (pready[2]) seen++;
    end
    check("abort_no_pready", 32'(seen), 32'h0);
    rd(2, 8'h10, d);
    check("abort_unchanged", d, 32'hCAFE_F00D);

    // Reset during an access phase that is presenting read data
    wr(0, 8'h0C, 32'h8765_4321, 4'hF);
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h0C;
    @(negedge clk);
    penable[0] = 1'b1;
    @(negedge clk);
    check("pre_rst_prdata", prdata[0], 32'h8765_4321);
    presetn = 1'b0;
    #1;
    check("mid_rst_pready", {31'b0, pready[0]}, 32'h0);
    check("mid_rst_prdata", prdata[0], 32'h0);
    check("mid_rst_pslverr", {31'b0, pslverr[0]}, 32'h0);
    bus_idle(0);
    @(negedge clk);
    presetn = 1'b1;
    clear_model();
    rd(0, 8'h0C, d);
    check("mem_cleared", d, 32'h0);

    // Random traffic against the model
    for (int u = 0; u < NU; u++) begin
      for (int k = 0; k < 40; k++) begin
        logic [7:0] a;
        if ($urandom_range(0, 9) == 0) a = 8'($urandom);
        else a = 8'($urandom_range(0, 31) * 4);
        xfer(u, 1'($urandom), a, $urandom, 4'($urandom), 1'($urandom), d);
      end
      @(negedge clk);
      bus_idle(u);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
